// File: rtl/shift_sub_divider_pkg.sv
// ----------------------------------------------------------------------
// shift_sub_divider_pkg : shared widths and FSM state type.  Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package shift_sub_divider_pkg;

  localparam int DEFAULT_N = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_sub_divider_if.sv
// ----------------------------------------------------------------------
// shift_sub_divider_if : request/result bundle of the divider.  Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface shift_sub_divider_if
  import shift_sub_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  logic             start;
  logic [2*N-1:0]   dvd;
  logic [N-1:0]     dvs;
  logic [N-1:0]     q;
  logic [N-1:0]     r;
  logic             ready;
  logic             busy;
  logic             ovf;
  logic             divz;

  modport master (output start, dvd, dvs,
                  input  q, r, ready, busy, ovf, divz);
  modport slave  (input  start, dvd, dvs,
                  output q, r, ready, busy, ovf, divz);
endinterface

`default_nettype wire

// File: rtl/shift_sub_divider_div_step.sv
// ----------------------------------------------------------------------
// div_step : one restoring shift-subtract iteration on W.  Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module div_step
  import shift_sub_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [2*N-1:0] w,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] w_next
);

  logic [N:0]   trial;
  logic [N-1:0] diff;
  logic         take;

  always_comb begin
    trial  = w[2*N-1:N-1];
    take   = (trial >= {1'b0, divisor});
    // The partial remainder stays below the divisor, so the difference fits in N bits.
    diff   = trial[N-1:0] - divisor;
    w_next = take ? {diff, w[N-2:0], 1'b1} : {trial[N-1:0], w[N-2:0], 1'b0};
  end

endmodule

`default_nettype wire

// File: rtl/shift_sub_divider.sv
// ----------------------------------------------------------------------
// shift_sub_divider : sequential restoring divider, 2N / N -> Q, R.  Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                clk,
  input  logic                rst,
  shift_sub_divider_if.slave  bus
);

  localparam int CW = cnt_width(N);

  state_t          state, state_next;
  logic [2*N-1:0]  w, w_next, step_w;
  logic [N-1:0]    divisor, divisor_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [N-1:0]    quot, quot_next;
  logic [N-1:0]    rem, rem_next;
  logic            ovf_flag, ovf_next;
  logic            divz_flag, divz_next;
  logic            divz_chk, ovf_chk;

  div_step #(.N(N)) u_step (
    .w       (w),
    .divisor (divisor),
    .w_next  (step_w)
  );

  always_comb begin
    state_next   = state;
    w_next       = w;
    divisor_next = divisor;
    cnt_next     = cnt;
    quot_next    = quot;
    rem_next     = rem;
    ovf_next     = ovf_flag;
    divz_next    = divz_flag;
    divz_chk     = (bus.dvs == '0);
    ovf_chk      = (bus.dvd[2*N-1:N] >= bus.dvs) && !divz_chk;

    if (bus.start) begin
      // A new request always wins, aborting any iteration in flight.
      w_next       = bus.dvd;
      divisor_next = bus.dvs;
      cnt_next     = '0;
      ovf_next     = ovf_chk;
      divz_next    = divz_chk;
      if (divz_chk || ovf_chk) begin
        state_next = DONE;
        quot_next  = '1;
        rem_next   = '0;
      end else begin
        state_next = RUN;
      end
    end else if (state == RUN) begin
      w_next   = step_w;
      cnt_next = cnt + CW'(1);
      if (cnt == CW'(N - 1)) begin
        state_next = DONE;
        quot_next  = step_w[N-1:0];
        rem_next   = step_w[2*N-1:N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      divisor   <= '0;
      cnt       <= '0;
      quot      <= '0;
      rem       <= '0;
      ovf_flag  <= 1'b0;
      divz_flag <= 1'b0;
    end else begin
      state     <= state_next;
      w         <= w_next;
      divisor   <= divisor_next;
      cnt       <= cnt_next;
      quot      <= quot_next;
      rem       <= rem_next;
      ovf_flag  <= ovf_next;
      divz_flag <= divz_next;
    end
  end

  assign bus.q     = quot;
  assign bus.r     = rem;
  assign bus.ovf   = ovf_flag;
  assign bus.divz  = divz_flag;
  assign bus.ready = (state == DONE);
  assign bus.busy  = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
// ----------------------------------------------------------------------
// tb_shift_sub_divider : vector table plus scoreboard for the divider.  Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_shift_sub_divider;
  import shift_sub_divider_pkg::*;

  localparam int N = DEFAULT_N;

  typedef struct {
    logic [2*N-1:0] dvd;
    logic [N-1:0]   dvs;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           ovf;
    logic           divz;
    int             lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  vec_t exp_q[$];

  shift_sub_divider_if #(.N(N)) bus ();

  shift_sub_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    vec_t v;
    v.dvd = a; v.dvs = b; v.ovf = 1'b0; v.divz = 1'b0;
    if (b == 0) begin
      v.divz = 1'b1; v.q = '1; v.r = '0; v.lat = 0;
    end else if ((a / b) > ((1 << N) - 1)) begin
      v.ovf = 1'b1; v.q = '1; v.r = '0; v.lat = 0;
    end else begin
      v.q = N'(a / b); v.r = N'(a % b); v.lat = N;
    end
    return v;
  endfunction

  task automatic issue(input vec_t v, input bit track);
    bus.start = 1'b1;
    bus.dvd   = v.dvd;
    bus.dvs   = v.dvs;
    if (track) exp_q.push_back(v);
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for READY; n counts edges already elapsed since the START edge.
  task automatic wait_result(input int already);
    int   n;
    vec_t e;
    n = already;
    while (bus.ready !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    if (bus.ready !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      check("unexpected_result", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("q",       32'(bus.q),    32'(e.q));
      check("r",       32'(bus.r),    32'(e.r));
      check("ovf",     32'(bus.ovf),  32'(e.ovf));
      check("divz",    32'(bus.divz), 32'(e.divz));
      check("latency", n,             e.lat);
      check("busy_with_ready", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    logic [N-1:0] rq, rd, rr;

    tbl[0] = '{dvd: 143, dvs: 11, q: 13, r: 0,  ovf: 0, divz: 0, lat: 4};
    tbl[1] = '{dvd: 200, dvs: 13, q: 15, r: 5,  ovf: 0, divz: 0, lat: 4};
    tbl[2] = '{dvd: 225, dvs: 15, q: 15, r: 0,  ovf: 0, divz: 0, lat: 4};
    tbl[3] = '{dvd: 255, dvs: 15, q: 15, r: 0,  ovf: 1, divz: 0, lat: 0};
    tbl[4] = '{dvd: 100, dvs: 0,  q: 15, r: 0,  ovf: 0, divz: 1, lat: 0};
    tbl[5] = '{dvd: 239, dvs: 15, q: 15, r: 14, ovf: 0, divz: 0, lat: 4};
    tbl[6] = '{dvd: 240, dvs: 15, q: 15, r: 0,  ovf: 1, divz: 0, lat: 0};
    tbl[7] = '{dvd: 0,   dvs: 0,  q: 15, r: 0,  ovf: 0, divz: 1, lat: 0};
    tbl[8] = '{dvd: 7,   dvs: 1,  q: 7,  r: 0,  ovf: 0, divz: 0, lat: 4};

    rst = 1'b1; bus.start = 1'b0; bus.dvd = '0; bus.dvs = '0;
    tick(); tick();
    check("rst_q",     32'(bus.q),     32'd0);
    check("rst_r",     32'(bus.r),     32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_divz",  32'(bus.divz),  32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i], 1'b1);
      if (tbl[i].lat != 0) begin
        check("start_busy",       32'(bus.busy),              32'd1);
        check("start_flags_clear", 32'({bus.ovf, bus.divz}), 32'd0);
      end
      wait_result(0);
    end

    for (int i = 0; i < 6; i++) begin
      rd = N'($urandom_range(1, (1 << N) - 1));
      rq = N'($urandom_range(0, (1 << N) - 1));
      rr = N'($urandom_range(0, int'(rd) - 1));
      v  = model((2*N)'(rq) * (2*N)'(rd) + (2*N)'(rr), rd);
      issue(v, 1'b1);
      wait_result(0);
    end

    // Restart on the third RUN edge: only the second request may complete.
    issue(model(143, 11), 1'b0);
    tick();
    check("abort_no_ready", 32'(bus.ready), 32'd0);
    tick();
    issue(model(200, 13), 1'b1);
    wait_result(0);

    // Back-to-back: new START while READY is high; old Q/R hold through RUN.
    issue(model(143, 11), 1'b1);
    wait_result(0);
    issue(model(200, 13), 1'b1);
    check("b2b_ready_drop", 32'(bus.ready), 32'd0);
    check("b2b_busy",       32'(bus.busy),  32'd1);
    check("b2b_q_hold",     32'(bus.q),     32'd13);
    tick();
    check("b2b_r_hold",     32'(bus.r),     32'd0);
    wait_result(1);

    // Reset together with START in mid-RUN clears everything.
    issue(model(225, 15), 1'b0);
    tick();
    rst = 1'b1; bus.start = 1'b1; bus.dvd = 8'd143; bus.dvs = 4'd11;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check("rst2_q",     32'(bus.q),     32'd0);
    check("rst2_r",     32'(bus.r),     32'd0);
    check("rst2_ready", 32'(bus.ready), 32'd0);
    check("rst2_busy",  32'(bus.busy),  32'd0);
    tick();
    check("rst2_idle",  32'({bus.ready, bus.busy}), 32'd0);

    issue(model(143, 11), 1'b1);
    wait_result(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
